// File: rtl/io_input_conditioner.sv
// Input pin conditioner: per-bit synchronizer chain plus optional debounce.
// Define IO_INPUT_DEBOUNCE_EN to include the per-bit debounce counters.
module io_input_conditioner #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_pins,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_changed
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("io_input_conditioner: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;
  logic [WIDTH-1:0]                  out_q, out_d;
  logic [WIDTH-1:0]                  chg_q, chg_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_pins};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef IO_INPUT_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronized bit agrees with the accepted value
  // discards all progress, so a bit flips only after an unbroken run.
  always_comb begin
    out_d = out_q;
    chg_d = '0;
    cnt_d = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (s[b] != out_q[b]) begin
        if (cnt_q[b] == TERM) begin
          out_d[b] = ~out_q[b];
          chg_d[b] = 1'b1;
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    out_d = s;
    chg_d = s ^ out_q;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
      chg_q <= '0;
    end else begin
      out_q <= out_d;
      chg_q <= chg_d;
    end
  end

  assign out_port    = out_q;
  assign out_changed = chg_q;

endmodule
